axi4s_wrr_scheduler: RTL
========================

// Module: axi4s_wrr_scheduler
// PURPOSE
//  Weighted round-robin packet scheduler for an N:1 AXI4-S master-to-slave mux.
//  Watches per-master tvalid and the muxed output handshake, and issues a registered grant (index + one-hot).
//  Grants are packet-atomic: held from grant until the tlast handshake.
//  Each master gets up to cfg weight consecutive packets per turn; weight 0 disables the master.
// PARAMETERS
//  NR_OF_MASTERS_P   4   number of requesting masters, >= 2
//  WEIGHT_WIDTH_P    4   width of each per-master weight (packets per turn)
// PORTS
//  clk          in   1                         clock
//  rst          in   1                         synchronous reset, active-high
//  cfg_weight   in   N*WEIGHT_WIDTH_P          per-master weights, master i at [i*W +: W]
//  cfg_update   in   1                         pulse: capture cfg_weight as pending config
//  req_tvalid   in   N                         tvalid of each master
//  beat_tvalid  in   1                         muxed slave-side tvalid
//  beat_tready  in   1                         slave-side tready
//  beat_tlast   in   1                         muxed slave-side tlast
//  gnt_valid    out  1                         a master is granted
//  gnt_index    out  IDX_W                     granted master, IDX_W = max(1,$clog2(N))
//  gnt_onehot   out  N                         one-hot of gnt_index, all-zero when !gnt_valid
// BEHAVIOUR
//  Reset: IDLE_E; gnt_valid=0; gnt_index=0; gnt_onehot=0; ptr=0; active weights all 1; credit=1; pending flag=0.
//  FSM IDLE_E:
//   - Search masters ptr, ptr+1, ... wrapping at N-1 -> 0.
//   - Winner w = first master with req_tvalid[w]=1 and weight[w]!=0.
//   - If a winner exists: GRANT_E next cycle with gnt_valid=1, gnt_index=w, one-hot set.
//   - If w!=ptr: ptr<=w, credit<=weight[w].
//   - No winner: stay in IDLE_E, outputs 0.
//  FSM GRANT_E:
//   - Packet end = beat_tvalid & beat_tready & beat_tlast.
//   - Grant is held unchanged until packet end, even if req_tvalid drops.
//   - On packet end: IDLE_E next cycle, gnt_valid=0, gnt_onehot=0; gnt_index holds its value.
//   - Credit: if credit==1 then ptr<=(ptr+1) mod N and credit<=weight[new ptr]; else credit<=credit-1.
//   - tlast without tready is not a packet end.
//  Latency:
//   - Request visible in IDLE at cycle n -> gnt_valid at n+1.
//   - Packet end at cycle m -> gnt_valid=0 at m+1 -> earliest next grant at m+2.
//   - Exactly one bubble cycle between packets.
//  Config:
//   - cfg_update latches cfg_weight into pending regs and sets the pending flag; a later pulse overwrites pending.
//   - Pending is applied in any cycle with state==IDLE_E and the flag set: active<=pending, credit<=pending[ptr], flag cleared.
//   - The search in that same cycle uses the old weights.
//   - A cfg_update in the same cycle as an apply: the new value is captured and stays pending.
//  Boundaries:
//   - All weights 0 -> never grants.
//   - ptr is never >= N; wrap uses explicit compare with N-1, not width overflow.
//   - credit is never 0 while its master is eligible.
//   - Reset mid-packet: all state to reset values; gnt_valid=0 the next cycle.
//   - Upstream packet truncation on reset is the system's concern.
// STRUCTURE
//  Package axi4s_wrr_scheduler_pkg:
//   - sched_state_t enum {IDLE_E, GRANT_E}.
//   - Function idx_width(n) returning max(1,$clog2(n)).
//  Sub-module rr_first_one_finder: combinational
//   - in: req mask N, start ptr.
//   - out: found, index of first set bit at or after ptr, with wrap.
//  Top holds the FSM, ptr, credit, active/pending weight regs, and the output regs.
// TESTING
//  1 Reset, weights all 1, req_tvalid=4'b1111, 1-beat packets, tready=1:
//    grants 0,1,2,3,0; gnt_valid high 1 cycle, low 1 cycle.
//  2 cfg weights {3,1,1,1} + update, all requesting:
//    grant order 0,0,0,1,2,3,0,0,0.
//  3 weight[2]=0, all requesting: order 0,1,3,0,1,3; M2 is never granted.
//  4 M1 4-beat packet, tready low 2 cycles mid-packet and on the tlast beat:
//    gnt_index=1 held until the tlast handshake; gnt_valid drops one cycle later.
//  5 ptr=0, only req_tvalid[3]=1: gnt_index=3 one cycle later; next search starts at 3 (weight 1 -> ptr=0 after).
//  6 cfg_update during GRANT_E: weights change only after the packet end.
//    Also: rst asserted mid-packet -> gnt_valid=0, ptr=0 the next cycle.

Source files
------------

// File: rtl/axi4s_wrr_scheduler_pkg.sv
// Shared types and helpers for the AXI4-Stream weighted round-robin packet scheduler.
package axi4s_wrr_scheduler_pkg;

    typedef enum logic [0:0] {
        IDLE_E  = 1'b0,
        GRANT_E = 1'b1
    } sched_state_t;

    function automatic int idx_width(input int n);
        if ($clog2(n) < 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/rr_first_one_finder.sv
// Combinational rotating priority search: first set request bit at or after ptr_i, wrapping at N_P-1.
module rr_first_one_finder
    import axi4s_wrr_scheduler_pkg::*;
#(
    parameter int N_P     = 4,
    parameter int IDX_W_P = 2
) (
    input  logic [N_P-1:0]     req_i,
    input  logic [IDX_W_P-1:0] ptr_i,
    output logic               found_o,
    output logic [IDX_W_P-1:0] index_o
);

    logic [IDX_W_P:0]   cand_s;
    logic [IDX_W_P-1:0] cand_idx_s;

    // Walk offsets from the pointer; the wrap is an explicit compare so non-power-of-two N works
    always_comb begin
        found_o    = 1'b0;
        index_o    = {IDX_W_P{1'b0}};
        cand_s     = {(IDX_W_P+1){1'b0}};
        cand_idx_s = {IDX_W_P{1'b0}};
        for (int off = 0; off < N_P; off++) begin
            cand_s = {1'b0, ptr_i} + (IDX_W_P+1)'(off);
            if (cand_s >= (IDX_W_P+1)'(N_P)) begin
                cand_s = cand_s - (IDX_W_P+1)'(N_P);
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = cand_s[IDX_W_P-1:0];
            if (!found_o && req_i[cand_idx_s]) begin
                found_o = 1'b1;
                index_o = cand_idx_s;
            end else begin
                found_o = found_o;
            end
        end
    end

endmodule

// File: rtl/axi4s_wrr_scheduler.sv
// N:1 AXI4-Stream weighted round-robin packet scheduler: packet-atomic registered grants,
// per-master packet credits per turn, and a shadowed weight configuration applied only while idle.
module axi4s_wrr_scheduler
    import axi4s_wrr_scheduler_pkg::*;
#(
    parameter int NR_OF_MASTERS_P = 4,
    parameter int WEIGHT_WIDTH_P  = 4,
    localparam int IDX_W          = idx_width(NR_OF_MASTERS_P)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [NR_OF_MASTERS_P*WEIGHT_WIDTH_P-1:0] cfg_weight_i,
    input  logic                                      cfg_update_i,
    input  logic [NR_OF_MASTERS_P-1:0]                req_tvalid_i,
    input  logic                                      beat_tvalid_i,
    input  logic                                      beat_tready_i,
    input  logic                                      beat_tlast_i,
    output logic                                      gnt_valid_o,
    output logic [IDX_W-1:0]                          gnt_index_o,
    output logic [NR_OF_MASTERS_P-1:0]                gnt_onehot_o
);

    localparam int N = NR_OF_MASTERS_P;
    localparam int W = WEIGHT_WIDTH_P;

    sched_state_t   state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [W-1:0]   credit_q, credit_d;
    logic [W-1:0]   active_w_q [N];
    logic [W-1:0]   active_w_d [N];
    logic [W-1:0]   pending_w_q [N];
    logic [W-1:0]   pending_w_d [N];
    logic           pending_q, pending_d;
    logic           gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0] gnt_index_q, gnt_index_d;
    logic [N-1:0]   gnt_onehot_q, gnt_onehot_d;

    logic [W-1:0]   cfg_arr_s [N];
    logic [N-1:0]   eligible_s;
    logic           found_s;
    logic [IDX_W-1:0] winner_s;
    logic           pkt_end_s;
    logic [IDX_W-1:0] ptr_next_s;

    // Unpack configuration and build the eligibility mask from the active weights
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cfg_arr_s[i]  = cfg_weight_i[i*W +: W];
            eligible_s[i] = req_tvalid_i[i] & (active_w_q[i] != {W{1'b0}});
        end
    end

    assign pkt_end_s  = beat_tvalid_i & beat_tready_i & beat_tlast_i;
    assign ptr_next_s = (ptr_q == IDX_W'(N-1)) ? {IDX_W{1'b0}} : (ptr_q + IDX_W'(1));

    rr_first_one_finder #(
        .N_P     (N),
        .IDX_W_P (IDX_W)
    ) u_finder (
        .req_i   (eligible_s),
        .ptr_i   (ptr_q),
        .found_o (found_s),
        .index_o (winner_s)
    );

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE_E;
            ptr_q        <= {IDX_W{1'b0}};
            credit_q     <= W'(1'b1);
            pending_q    <= 1'b0;
            gnt_valid_q  <= 1'b0;
            gnt_index_q  <= {IDX_W{1'b0}};
            gnt_onehot_q <= {N{1'b0}};
            for (int i = 0; i < N; i++) begin
                active_w_q[i]  <= W'(1'b1);
                pending_w_q[i] <= W'(1'b1);
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            credit_q     <= credit_d;
            pending_q    <= pending_d;
            gnt_valid_q  <= gnt_valid_d;
            gnt_index_q  <= gnt_index_d;
            gnt_onehot_q <= gnt_onehot_d;
            for (int i = 0; i < N; i++) begin
                active_w_q[i]  <= active_w_d[i];
                pending_w_q[i] <= pending_w_d[i];
            end
        end
    end

    // Next-state: leave IDLE on a winner, leave GRANT only on the tlast handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE_E: begin
                if (found_s) begin
                    state_d = GRANT_E;
                end else begin
                    state_d = IDLE_E;
                end
            end
            GRANT_E: begin
                if (pkt_end_s) begin
                    state_d = IDLE_E;
                end else begin
                    state_d = GRANT_E;
                end
            end
            default: state_d = IDLE_E;
        endcase
    end

    // Grant outputs, pointer/credit bookkeeping and config shadowing
    always_comb begin
        ptr_d        = ptr_q;
        credit_d     = credit_q;
        pending_d    = pending_q;
        gnt_valid_d  = gnt_valid_q;
        gnt_index_d  = gnt_index_q;
        gnt_onehot_d = gnt_onehot_q;
        for (int i = 0; i < N; i++) begin
            active_w_d[i]  = active_w_q[i];
            pending_w_d[i] = pending_w_q[i];
        end
        case (state_q)
            IDLE_E: begin
                // The search this cycle still sees the old weights; the new ones take effect next cycle
                if (pending_q) begin
                    for (int i = 0; i < N; i++) begin
                        active_w_d[i] = pending_w_q[i];
                    end
                    credit_d  = pending_w_q[ptr_q];
                    pending_d = 1'b0;
                end else begin
                    pending_d = pending_q;
                end
                if (found_s) begin
                    gnt_valid_d  = 1'b1;
                    gnt_index_d  = winner_s;
                    gnt_onehot_d = {{(N-1){1'b0}}, 1'b1} << winner_s;
                    if (winner_s != ptr_q) begin
                        ptr_d    = winner_s;
                        credit_d = active_w_q[winner_s];
                    end else begin
                        ptr_d = ptr_q;
                    end
                end else begin
                    gnt_valid_d  = 1'b0;
                    gnt_onehot_d = {N{1'b0}};
                end
            end
            GRANT_E: begin
                if (pkt_end_s) begin
                    gnt_valid_d  = 1'b0;
                    gnt_onehot_d = {N{1'b0}};
                    // A zero credit (weight cleared under a live turn) is treated as the last packet
                    if (credit_q <= W'(1'b1)) begin
                        ptr_d    = ptr_next_s;
                        credit_d = active_w_q[ptr_next_s];
                    end else begin
                        credit_d = credit_q - W'(1'b1);
                    end
                end else begin
                    gnt_valid_d = gnt_valid_q;
                end
            end
            default: begin
                gnt_valid_d  = 1'b0;
                gnt_onehot_d = {N{1'b0}};
            end
        endcase
        if (cfg_update_i) begin
            for (int i = 0; i < N; i++) begin
                pending_w_d[i] = cfg_arr_s[i];
            end
            pending_d = 1'b1;
        end else begin
            pending_d = pending_d;
        end
    end

    assign gnt_valid_o  = gnt_valid_q;
    assign gnt_index_o  = gnt_index_q;
    assign gnt_onehot_o = gnt_onehot_q;

endmodule
